macc_frame_pipelined: RTL and testbench

Parametrised, fully pipelined multiply-accumulate for NCO/filter datapaths. It registers the inputs and the product (three stages), accumulates samples over frames marked by `in_last`, and emits one result per frame with an overflow flag. It also supports optional saturation. There is no bubble between frames, and it sustains one sample per clock. It is the generalised successor to the fixed 16-bit single-stage MAC, intended to map onto one DSP48E slice.

---
 rtl/macc_frame_pipelined.sv | 106 ++++++++++
 tb/tb_macc_frame_pipelined.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/macc_frame_pipelined.sv
// Three-stage pipelined multiply-accumulate: registered operands, registered product, and a
// frame accumulator that reports each frame's sum with a sticky overflow flag.
module macc_frame_pipelined #(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH = 48,
    parameter bit          SIGNED    = 1'b1,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_sync,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_result,
    output logic                 out_overflow
);

    localparam int unsigned PW = A_WIDTH + B_WIDTH;
    localparam int unsigned SW = ACC_WIDTH + 1;

    if (ACC_WIDTH < PW) begin : g_width_check
        $error("ACC_WIDTH must be at least A_WIDTH + B_WIDTH");
    end

    localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [A_WIDTH-1:0]   a_q;
    logic [B_WIDTH-1:0]   b_q;
    logic                 s1_valid_q, s1_last_q;
    logic [PW-1:0]        p_q;
    logic                 s2_valid_q, s2_last_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_q;
    logic                 first_q;

    logic [PW-1:0]        a_ext, b_ext, prod;
    logic [SW-1:0]        p_ext, base, sum;
    logic                 overflow;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 ovf_d;

    // Low PW bits of the product of extended operands equal the exact product in either mode.
    assign a_ext = {{B_WIDTH{SIGNED & a_q[A_WIDTH-1]}}, a_q};
    assign b_ext = {{A_WIDTH{SIGNED & b_q[B_WIDTH-1]}}, b_q};
    assign prod  = a_ext * b_ext;

    always_comb begin
        p_ext = {{(SW-PW){SIGNED & p_q[PW-1]}}, p_q};
        base  = first_q ? '0 : {SIGNED & acc_q[ACC_WIDTH-1], acc_q};
        sum   = base + p_ext;
        // Signed: top two bits disagree; unsigned: carry out of the accumulator width.
        overflow = SIGNED ? (sum[SW-1] ^ sum[SW-2]) : sum[SW-1];
        acc_d = sum[ACC_WIDTH-1:0];
        if (overflow && SATURATE) begin
            if (SIGNED) begin
                acc_d = sum[SW-1] ? SMIN : SMAX;
            end else begin
                acc_d = UMAX;
            end
        end
        ovf_d = (first_q ? 1'b0 : ovf_q) | overflow;
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            a_q          <= '0;
            b_q          <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            p_q          <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            first_q      <= 1'b1;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
        end else begin
            a_q        <= a;
            b_q        <= b;
            s1_valid_q <= in_valid;
            s1_last_q  <= in_valid & in_last;
            p_q        <= prod;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            out_valid  <= 1'b0;
            if (s2_valid_q) begin
                acc_q   <= acc_d;
                ovf_q   <= ovf_d;
                first_q <= s2_last_q;
                if (s2_last_q) begin
                    out_valid    <= 1'b1;
                    out_result   <= acc_d;
                    out_overflow <= ovf_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_macc_frame_pipelined.sv
// Directed-vector bench for macc_frame_pipelined: four configurations, queue scoreboards and
// per-instance monitors that check value, overflow flag and arrival cycle of each frame result.
module tb_macc_frame_pipelined;

    typedef struct {
        logic [47:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_sync = 1'b1;
    logic        in_v = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sel_s = 1'b0, sel_32 = 1'b0, sel_u = 1'b0;

    logic        ov_s, ov_w, ov_t, ov_u;
    logic [47:0] res_s, res_u;
    logic [31:0] res_w, res_t;
    logic        of_s, of_w, of_t, of_u;

    int cyc = 0;
    int last_cyc = 0;
    int checks = 0;
    int errors = 0;

    exp_t q_s[$], q_w[$], q_t[$], q_u[$];
    exp_t e_s, e_w, e_t, e_u;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    macc_frame_pipelined dut_s (
        .clk(clk), .rst_sync(rst_sync), .in_valid(in_v & sel_s), .in_last(in_last),
        .a(a), .b(b), .out_valid(ov_s), .out_result(res_s), .out_overflow(of_s)
    );
    macc_frame_pipelined #(.ACC_WIDTH(32), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_sync(rst_sync), .in_valid(in_v & sel_32), .in_last(in_last),
        .a(a), .b(b), .out_valid(ov_w), .out_result(res_w), .out_overflow(of_w)
    );
    macc_frame_pipelined #(.ACC_WIDTH(32), .SATURATE(1'b1)) dut_t (
        .clk(clk), .rst_sync(rst_sync), .in_valid(in_v & sel_32), .in_last(in_last),
        .a(a), .b(b), .out_valid(ov_t), .out_result(res_t), .out_overflow(of_t)
    );
    macc_frame_pipelined #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_sync(rst_sync), .in_valid(in_v & sel_u), .in_last(in_last),
        .a(a), .b(b), .out_valid(ov_u), .out_result(res_u), .out_overflow(of_u)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s_unexpected: out_valid with empty scoreboard at cycle %0d", name, cyc);
    endtask

    // Monitors: outputs change on posedge, so sample on negedge.
    always @(negedge clk) begin
        if (ov_s === 1'b1) begin
            if (q_s.size() == 0) unexpected("s");
            else begin
                e_s = q_s.pop_front();
                chk("s_result", {16'h0, res_s}, {16'h0, e_s.res});
                chk("s_ovf", {63'h0, of_s}, {63'h0, e_s.ovf});
                chk("s_cycle", 64'(cyc), 64'(e_s.cyc));
            end
        end
        if (ov_w === 1'b1) begin
            if (q_w.size() == 0) unexpected("w");
            else begin
                e_w = q_w.pop_front();
                chk("w_result", {32'h0, res_w}, {16'h0, e_w.res});
                chk("w_ovf", {63'h0, of_w}, {63'h0, e_w.ovf});
                chk("w_cycle", 64'(cyc), 64'(e_w.cyc));
            end
        end
        if (ov_t === 1'b1) begin
            if (q_t.size() == 0) unexpected("t");
            else begin
                e_t = q_t.pop_front();
                chk("t_result", {32'h0, res_t}, {16'h0, e_t.res});
                chk("t_ovf", {63'h0, of_t}, {63'h0, e_t.ovf});
                chk("t_cycle", 64'(cyc), 64'(e_t.cyc));
            end
        end
        if (ov_u === 1'b1) begin
            if (q_u.size() == 0) unexpected("u");
            else begin
                e_u = q_u.pop_front();
                chk("u_result", {16'h0, res_u}, {16'h0, e_u.res});
                chk("u_ovf", {63'h0, of_u}, {63'h0, e_u.ovf});
                chk("u_cycle", 64'(cyc), 64'(e_u.cyc));
            end
        end
    end

    // Input driven at a negedge is sampled by the next posedge; its result appears 3 edges later.
    task automatic drive(input int av, input int bv, input logic lst);
        @(negedge clk);
        a        = av[15:0];
        b        = bv[15:0];
        in_last  = lst;
        in_v     = 1'b1;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_v    = 1'b0;
            in_last = 1'b0;
        end
    endtask

    function automatic exp_t mk(input logic [47:0] r, input logic o);
        exp_t e;
        e.res = r;
        e.ovf = o;
        e.cyc = last_cyc + 3;
        return e;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_s_zero"}, {14'h0, ov_s, of_s, res_s}, 64'h0);
        chk({tag, "_w_zero"}, {30'h0, ov_w, of_w, res_w}, 64'h0);
        chk({tag, "_t_zero"}, {30'h0, ov_t, of_t, res_t}, 64'h0);
        chk({tag, "_u_zero"}, {14'h0, ov_u, of_u, res_u}, 64'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_sync = 1'b0;

        // Basic frame: 12 - 10 - 7 = -5
        sel_s = 1'b1;
        drive(3, 4, 1'b0);
        drive(-2, 5, 1'b0);
        drive(7, -1, 1'b1);
        q_s.push_back(mk(48'hFFFF_FFFF_FFFB, 1'b0));
        idle(6);

        // Back-to-back frames, second one single-sample
        drive(1, 1, 1'b0);
        drive(2, 2, 1'b1);
        q_s.push_back(mk(48'd5, 1'b0));
        drive(10, 10, 1'b1);
        q_s.push_back(mk(48'd100, 1'b0));
        idle(6);

        // Bubbles between samples
        drive(3, 4, 1'b0);
        idle(2);
        drive(-2, 5, 1'b0);
        idle(2);
        drive(7, -1, 1'b1);
        q_s.push_back(mk(48'hFFFF_FFFF_FFFB, 1'b0));
        idle(6);
        sel_s = 1'b0;

        // 32-bit wrap vs saturate, positive then negative excursion, then a clean frame
        sel_32 = 1'b1;
        drive(32767, 32767, 1'b0);
        drive(32767, 32767, 1'b0);
        drive(32767, 32767, 1'b1);
        q_w.push_back(mk(48'h0000_BFFD_0003, 1'b1));
        q_t.push_back(mk(48'h0000_7FFF_FFFF, 1'b1));
        drive(1, 1, 1'b1);
        q_w.push_back(mk(48'd1, 1'b0));
        q_t.push_back(mk(48'd1, 1'b0));
        drive(-32768, 32767, 1'b0);
        drive(-32768, 32767, 1'b0);
        drive(-32768, 32767, 1'b1);
        q_w.push_back(mk(48'h0000_4001_8000, 1'b1));
        q_t.push_back(mk(48'h0000_8000_0000, 1'b1));
        drive(1, 1, 1'b1);
        q_w.push_back(mk(48'd1, 1'b0));
        q_t.push_back(mk(48'd1, 1'b0));
        idle(6);
        sel_32 = 1'b0;

        // Unsigned mode
        sel_u = 1'b1;
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        q_u.push_back(mk(48'h0000_FFFE_0001, 1'b0));
        drive(16'hFFFF, 16'hFFFF, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        q_u.push_back(mk(48'h0001_FFFC_0002, 1'b0));
        idle(6);
        sel_u = 1'b0;

        // Reset while a frame is still in the pipeline: its result must never appear
        sel_s = 1'b1;
        drive(5, 5, 1'b0);
        drive(6, 6, 1'b1);
        @(negedge clk);
        in_v     = 1'b0;
        rst_sync = 1'b1;
        @(negedge clk);
        rst_sync = 1'b0;
        check_zero("midrst");
        drive(2, 3, 1'b1);
        q_s.push_back(mk(48'd6, 1'b0));
        idle(8);

        for (int i = 0; i < 50; i++) begin
            if (q_s.size() + q_w.size() + q_t.size() + q_u.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (q_s.size() + q_w.size() + q_t.size() + q_u.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, want 0",
                     q_s.size() + q_w.size() + q_t.size() + q_u.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
